apb_requester: RTL and testbench

- APB4 requester (manager) for the team's APB completer blocks.
- Accepts single read/write commands on a valid/ready command port and runs the standard SETUP -> ACCESS APB transfer, inserting wait states while PREADY is low.
- Returns read data and error status on a one-cycle response strobe.
- Supports back-to-back transfers, rejects misaligned addresses locally, and aborts hung transfers with a wait-state timeout.

---
 rtl/apb_requester.sv | 184 ++++++++++++++++++
 tb/tb_apb_requester.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// APB4 requester: runs one SETUP -> ACCESS transfer per accepted command,
// returning read data / error status on a single-cycle response strobe.
// Ports:
//   pclk, presetn        clock, async active-low reset
//   cmd_*                valid/ready command port (write, addr, wdata, strb, prot)
//   rsp_*                response strobe with rdata, slverr, timeout flags
//   psel..pprot          APB request outputs
//   prdata/pready/pslverr APB completer inputs
module apb_requester #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   input  logic [2:0]              cmd_prot,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_slverr,
   output logic                    rsp_timeout,
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic [DATA_WIDTH-1:0]   pwdata,
   output logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [2:0]              pprot,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pready,
   input  logic                    pslverr
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned ALIGNBITS  = $clog2(STRB_WIDTH);
   localparam int unsigned CNT_WIDTH  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGNBITS) - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

   state_t                  r_state, w_state_nxt;
   logic [CNT_WIDTH-1:0]    r_wait, w_wait_nxt;
   logic                    r_mis_pend, w_mis_pend_nxt;
   logic                    r_psel, w_psel_nxt;
   logic                    r_penable, w_penable_nxt;
   logic                    r_pwrite, w_pwrite_nxt;
   logic [ADDR_WIDTH-1:0]   r_paddr, w_paddr_nxt;
   logic [DATA_WIDTH-1:0]   r_pwdata, w_pwdata_nxt;
   logic [STRB_WIDTH-1:0]   r_pstrb, w_pstrb_nxt;
   logic [2:0]              r_pprot, w_pprot_nxt;
   logic                    r_rsp_valid, w_rsp_valid_nxt;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
   logic                    r_rsp_slverr, w_rsp_slverr_nxt;
   logic                    r_rsp_timeout, w_rsp_timeout_nxt;

   logic w_done, w_tmo, w_accept, w_aligned, w_load, w_mis;

   // Transfer completion / timeout abort in the current ACCESS cycle
   assign w_done    = (r_state == S_ACCESS) && pready;
   assign w_tmo     = (r_state == S_ACCESS) && !pready && (TIMEOUT != 0) &&
                      (r_wait == CNT_WIDTH'(TIMEOUT));
   assign cmd_ready = (r_state == S_IDLE) || w_done;
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_aligned = ((cmd_addr & ALIGN_MASK) == '0);
   assign w_load    = w_accept && w_aligned;
   assign w_mis     = w_accept && !w_aligned;

   // Next-state, APB payload and response computation
   always_comb begin
      w_state_nxt       = r_state;
      w_wait_nxt        = r_wait;
      w_mis_pend_nxt    = 1'b0;
      w_pwrite_nxt      = r_pwrite;
      w_paddr_nxt       = r_paddr;
      w_pwdata_nxt      = r_pwdata;
      w_pstrb_nxt       = r_pstrb;
      w_pprot_nxt       = r_pprot;
      w_rsp_valid_nxt   = 1'b0;
      w_rsp_rdata_nxt   = r_rsp_rdata;
      w_rsp_slverr_nxt  = r_rsp_slverr;
      w_rsp_timeout_nxt = r_rsp_timeout;

      unique case (r_state)
         S_IDLE: begin
            if (w_load) w_state_nxt = S_SETUP;
         end
         S_SETUP: begin
            w_state_nxt = S_ACCESS;
            w_wait_nxt  = '0;
         end
         S_ACCESS: begin
            if (pready)              w_state_nxt = w_load ? S_SETUP : S_IDLE;
            else if (w_tmo)          w_state_nxt = S_IDLE;
            else if (r_wait != '1)   w_wait_nxt  = r_wait + 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_load) begin
         w_pwrite_nxt = cmd_write;
         w_paddr_nxt  = cmd_addr;
         w_pwdata_nxt = cmd_wdata;
         w_pstrb_nxt  = cmd_write ? cmd_strb : '0;
         w_pprot_nxt  = cmd_prot;
      end

      // A misaligned command taken at completion is answered one cycle after
      // the completion response, so it is parked in r_mis_pend.
      if (w_done) begin
         w_rsp_valid_nxt   = 1'b1;
         w_rsp_slverr_nxt  = pslverr;
         w_rsp_timeout_nxt = 1'b0;
         w_rsp_rdata_nxt   = (!r_pwrite && !pslverr) ? prdata : '0;
         w_mis_pend_nxt    = w_mis;
      end else if (w_tmo) begin
         w_rsp_valid_nxt   = 1'b1;
         w_rsp_slverr_nxt  = 1'b1;
         w_rsp_timeout_nxt = 1'b1;
         w_rsp_rdata_nxt   = '0;
      end else if (r_mis_pend || w_mis) begin
         w_rsp_valid_nxt   = 1'b1;
         w_rsp_slverr_nxt  = 1'b1;
         w_rsp_timeout_nxt = 1'b0;
         w_rsp_rdata_nxt   = '0;
         w_mis_pend_nxt    = r_mis_pend && w_mis;
      end

      w_psel_nxt    = (w_state_nxt != S_IDLE);
      w_penable_nxt = (w_state_nxt == S_ACCESS);
   end

   // State and output registers
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state       <= S_IDLE;
         r_wait        <= '0;
         r_mis_pend    <= 1'b0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_pstrb       <= '0;
         r_pprot       <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_slverr  <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_wait        <= w_wait_nxt;
         r_mis_pend    <= w_mis_pend_nxt;
         r_psel        <= w_psel_nxt;
         r_penable     <= w_penable_nxt;
         r_pwrite      <= w_pwrite_nxt;
         r_paddr       <= w_paddr_nxt;
         r_pwdata      <= w_pwdata_nxt;
         r_pstrb       <= w_pstrb_nxt;
         r_pprot       <= w_pprot_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_slverr  <= w_rsp_slverr_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
      end
   end

   assign psel        = r_psel;
   assign penable     = r_penable;
   assign pwrite      = r_pwrite;
   assign paddr       = r_paddr;
   assign pwdata      = r_pwdata;
   assign pstrb       = r_pstrb;
   assign pprot       = r_pprot;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_slverr  = r_rsp_slverr;
   assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester (TIMEOUT=4, 32-bit data).
module tb_apb_requester;

   localparam int TMO = 4;

   logic        pclk, presetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic [2:0]  cmd_prot;
   logic        rsp_valid, rsp_slverr, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        pready, pslverr;

   int total = 0;
   int bad   = 0;

   apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
      .pclk(pclk), .presetn(presetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
      .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   typedef struct {
      logic w; logic [31:0] a; logic [31:0] d; logic [3:0] s; logic [2:0] p;
      int waits; logic [31:0] rd; logic se;
      int e_lat; logic e_se; logic e_to; logic [31:0] e_rd; int e_acc; logic e_psel;
   } vec_t;

   typedef struct {
      int lat; int acc; logic psel_seen; logic apb_ok; logic rdy0; logic setup_ok;
      logic se; logic to; logic [31:0] rd;
   } obs_t;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Reference: outcome of one isolated command derived from the protocol rules
   function automatic vec_t model(vec_t v);
      vec_t e = v;
      if (v.a[1:0] != 2'b00) begin
         e.e_lat = 1; e.e_se = 1'b1; e.e_to = 1'b0; e.e_rd = '0; e.e_acc = 0; e.e_psel = 1'b0;
      end else if (TMO != 0 && v.waits > TMO) begin
         e.e_acc = TMO + 1; e.e_lat = 2 + e.e_acc; e.e_se = 1'b1; e.e_to = 1'b1;
         e.e_rd = '0; e.e_psel = 1'b1;
      end else begin
         e.e_acc = v.waits + 1; e.e_lat = 2 + e.e_acc; e.e_se = v.se; e.e_to = 1'b0;
         e.e_rd = (!v.w && !v.se) ? v.rd : '0; e.e_psel = 1'b1;
      end
      return e;
   endfunction

   // Issue one command from IDLE and play the completer; starts/ends just after a rising edge
   task automatic run_one(input vec_t v, output obs_t o);
      cmd_valid = 1'b1; cmd_write = v.w; cmd_addr = v.a; cmd_wdata = v.d;
      cmd_strb = v.s; cmd_prot = v.p; pready = 1'b0; pslverr = 1'b0; prdata = '0;
      o.lat = -1; o.acc = 0; o.psel_seen = 1'b0; o.apb_ok = 1'b1; o.rdy0 = 1'b0;
      o.setup_ok = 1'b0; o.se = 1'b0; o.to = 1'b0; o.rd = '0;
      for (int c = 0; c < 40 && o.lat < 0; c++) begin
         @(negedge pclk);
         if (c == 0) o.rdy0 = cmd_ready;
         if (c == 1) o.setup_ok = psel && !penable;
         if (rsp_valid) begin
            o.lat = c; o.se = rsp_slverr; o.to = rsp_timeout; o.rd = rsp_rdata;
         end
         if (psel) begin
            o.psel_seen = 1'b1;
            if (!(paddr == v.a && pwrite == v.w && pwdata == v.d &&
                  pstrb == (v.w ? v.s : 4'h0) && pprot == v.p)) o.apb_ok = 1'b0;
         end
         if (psel && penable) begin
            o.acc++;
            pready = (o.acc > v.waits); prdata = v.rd; pslverr = v.se;
         end else begin
            pready = 1'b0;
         end
         @(posedge pclk); #1;
         if (c == 0) cmd_valid = 1'b0;
      end
      pready = 1'b0; pslverr = 1'b0;
   endtask

   task automatic run_check(input vec_t e, input string tag);
      obs_t o;
      run_one(e, o);
      chk({tag, ".ready"},  64'(o.rdy0), 64'(1));
      chk({tag, ".lat"},    64'(o.lat), 64'(e.e_lat));
      chk({tag, ".slverr"}, 64'(o.se), 64'(e.e_se));
      chk({tag, ".tmo"},    64'(o.to), 64'(e.e_to));
      chk({tag, ".rdata"},  64'(o.rd), 64'(e.e_rd));
      chk({tag, ".access"}, 64'(o.acc), 64'(e.e_acc));
      chk({tag, ".psel"},   64'(o.psel_seen), 64'(e.e_psel));
      chk({tag, ".setup"},  64'(o.setup_ok), 64'(e.e_psel));
      chk({tag, ".stable"}, 64'(o.apb_ok), 64'(1));
      @(negedge pclk);
      chk({tag, ".pulse"},  64'(rsp_valid), 64'(0));
      @(posedge pclk); #1;
   endtask

   // Two commands with cmd_valid held; second address a2; 7-cycle trace compared bitwise
   task automatic b2b(input logic [31:0] a2, input logic [6:0] e_psel, input logic [6:0] e_pen,
                      input logic [6:0] e_rv, input logic e_se2, input logic [31:0] e_rd2,
                      input string tag);
      logic [6:0] t_psel, t_pen, t_rv;
      logic se2; logic [31:0] rd2;
      se2 = 1'b0; rd2 = '0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'h1111_2222;
      cmd_strb = 4'hF; cmd_prot = 3'b000; pready = 1'b1; prdata = 32'hCAFE_F00D; pslverr = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(negedge pclk);
         t_psel[c] = psel; t_pen[c] = penable; t_rv[c] = rsp_valid;
         if (rsp_valid) begin se2 = rsp_slverr; rd2 = rsp_rdata; end
         @(posedge pclk); #1;
         if (c == 0) begin cmd_write = 1'b0; cmd_addr = a2; cmd_strb = 4'h0; end
         if (c == 2) cmd_valid = 1'b0;
      end
      pready = 1'b0;
      chk({tag, ".psel"},    64'(t_psel), 64'(e_psel));
      chk({tag, ".penable"}, 64'(t_pen), 64'(e_pen));
      chk({tag, ".rsp"},     64'(t_rv), 64'(e_rv));
      chk({tag, ".slverr2"}, 64'(se2), 64'(e_se2));
      chk({tag, ".rdata2"},  64'(rd2), 64'(e_rd2));
   endtask

   vec_t tbl[7];

   initial begin
      //        w     addr          wdata         strb  prot  wt rdata        se  lat se to  rdata        acc psel
      tbl[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 32'h0,        1'b0, 3, 1'b0, 1'b0, 32'h0,        1, 1'b1};
      tbl[1] = '{1'b0, 32'h10, 32'h0,         4'hF, 3'b000, 3, 32'hDEAD_BEEF, 1'b0, 6, 1'b0, 1'b0, 32'hDEAD_BEEF, 4, 1'b1};
      tbl[2] = '{1'b0, 32'h6,  32'h0,         4'h0, 3'b000, 0, 32'h0,        1'b0, 1, 1'b1, 1'b0, 32'h0,        0, 1'b0};
      tbl[3] = '{1'b0, 32'h20, 32'h0,         4'h0, 3'b001, 0, 32'h1234,     1'b1, 3, 1'b1, 1'b0, 32'h0,        1, 1'b1};
      tbl[4] = '{1'b0, 32'h30, 32'h0,         4'h0, 3'b000, 50, 32'h0,       1'b0, 7, 1'b1, 1'b1, 32'h0,        5, 1'b1};
      tbl[5] = '{1'b0, 32'h34, 32'h0,         4'h0, 3'b100, 4, 32'h55AA,     1'b0, 7, 1'b0, 1'b0, 32'h55AA,     5, 1'b1};
      tbl[6] = '{1'b1, 32'h3,  32'h77,        4'h1, 3'b000, 0, 32'h0,        1'b0, 1, 1'b1, 1'b0, 32'h0,        0, 1'b0};

      presetn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10;
      cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF; cmd_prot = 3'b111;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      repeat (3) @(negedge pclk);
      chk("reset.apb", 64'({psel, penable, pwrite, pstrb, pprot}), 64'(0));
      chk("reset.addr_data", {paddr, pwdata}, 64'(0));
      chk("reset.rsp", 64'({rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata}), 64'(0));
      chk("reset.ready", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b0;
      presetn = 1'b1;
      @(posedge pclk); #1;

      for (int i = 0; i < 7; i++) run_check(tbl[i], $sformatf("vec%0d", i));

      b2b(32'h8, 7'b0011110, 7'b0010100, 7'b0101000, 1'b0, 32'hCAFE_F00D, "b2b_aligned");
      b2b(32'h6, 7'b0000110, 7'b0000100, 7'b0011000, 1'b1, 32'h0, "b2b_misaligned");

      // Reset during ACCESS: APB select drops at once and no response follows
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_strb = 4'h0; pready = 1'b0;
      @(posedge pclk); #1; cmd_valid = 1'b0;
      @(posedge pclk); #1;
      chk("midrst.in_access", 64'({psel, penable}), 64'(3));
      #2 presetn = 1'b0;
      #1 chk("midrst.async_drop", 64'({psel, penable}), 64'(0));
      @(negedge pclk); presetn = 1'b1;
      begin
         int seen = 0;
         repeat (5) begin @(negedge pclk); if (rsp_valid) seen++; end
         chk("midrst.no_rsp", 64'(seen), 64'(0));
      end
      @(posedge pclk); #1;

      for (int i = 0; i < 30; i++) begin
         vec_t v;
         v.w = 1'($urandom_range(0, 1));
         v.a = $urandom & 32'h0000_03FC;
         if ($urandom_range(0, 3) == 0) v.a[1:0] = 2'($urandom_range(1, 3));
         v.d = $urandom; v.s = 4'($urandom_range(0, 15)); v.p = 3'($urandom_range(0, 7));
         v.waits = $urandom_range(0, 6); v.rd = $urandom;
         v.se = ($urandom_range(0, 3) == 0);
         run_check(model(v), $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
